// File: rtl/dmem_arbiter_if.sv
// Purpose: bundles both requester ports and the data-memory port of the arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until they see their gnt.
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
);
    // Requester 0: CPU load/store path
    logic                  req0;
    logic                  we0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] wdata0;
    logic                  gnt0;
    logic                  rvalid0;
    logic [DATA_WIDTH-1:0] rdata0;

    // Requester 1: program/data loader
    logic                  req1;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt1;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata1;

    // Data memory side
    logic                  memRead;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;
    logic [DATA_WIDTH-1:0] memRdata;

    logic                  starved;

    // Seen from the requesters and the memory model
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output memRdata,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  memRead, memWrite, memAddr, memWdata,
        input  starved
    );

    // Seen from the arbiter
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  memRdata,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output memRead, memWrite, memAddr, memWdata,
        output starved
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: fixed-priority (req0 first) data-memory arbiter with starvation guard for req1.
// Latency: grant and memory drive are combinational; read data returns 1 cycle after grant.
// Backpressure: a denied requester holds req; req1 waits at most STARVE_LIMIT cycles.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          resetN,
    dmem_arbiter_if.slave bus
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] starve_cnt;
    logic       pend_vld;
    logic       pend_id;

    logic       force_one;
    logic       gnt0_w;
    logic       gnt1_w;
    logic       rd_issue;

    // Grant decision: req1 wins when forced or uncontested; grants are
    // masked during reset so every output reads 0 while resetN is low.
    always_comb begin
        force_one = (starve_cnt == LIMIT);
        gnt1_w    = resetN & bus.req1 & (force_one | ~bus.req0);
        gnt0_w    = resetN & bus.req0 & ~gnt1_w;
        rd_issue  = (gnt0_w & ~bus.we0) | (gnt1_w & ~bus.we1);
    end

    // Memory drive: granted requester's access passes straight through.
    always_comb begin
        bus.memRead  = 1'b0;
        bus.memWrite = 1'b0;
        bus.memAddr  = '0;
        bus.memWdata = '0;
        if (gnt0_w) begin
            bus.memRead  = ~bus.we0;
            bus.memWrite = bus.we0;
            bus.memAddr  = bus.addr0;
            bus.memWdata = bus.wdata0;
        end else if (gnt1_w) begin
            bus.memRead  = ~bus.we1;
            bus.memWrite = bus.we1;
            bus.memAddr  = bus.addr1;
            bus.memWdata = bus.wdata1;
        end
    end

    // Read tag: remember who issued the read so the returning data is steered.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_vld <= 1'b0;
            pend_id  <= 1'b0;
        end else begin
            pend_vld <= rd_issue;
            pend_id  <= rd_issue ? gnt1_w : 1'b0;
        end
    end

    // Starvation counter: counts consecutive denied req1 cycles, saturating
    // at the limit; any req1 grant or dropped req1 restarts the count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            starve_cnt <= 8'd0;
        end else if (!bus.req1 || gnt1_w) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Read return steering and status outputs.
    always_comb begin
        bus.gnt0    = gnt0_w;
        bus.gnt1    = gnt1_w;
        bus.rvalid0 = pend_vld & ~pend_id;
        bus.rvalid1 = pend_vld & pend_id;
        bus.rdata0  = bus.rvalid0 ? bus.memRdata : '0;
        bus.rdata1  = bus.rvalid1 ? bus.memRdata : '0;
        bus.starved = force_one;
    end

endmodule
